// File: rtl/gray_window_3x3_pkg.sv
// Shared definitions for the gray_window_3x3 stage.
//   stateT         : 2-bit frame-tracking FSM encoding
//   componentWidth : width S of one weighted colour term in a packed pixel
//   winIndex       : flat element index k = 3*r + c inside the 3x3 window
//   SUM_GUARD_BITS : extra bits so the three-term sum cannot overflow before saturation
package gray_window_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } stateT;

    localparam int NUM_COMPONENTS = 3;
    localparam int WIN_DIM        = 3;
    localparam int WIN_ELEMS      = WIN_DIM * WIN_DIM;
    localparam int SUM_GUARD_BITS = 2;

    function automatic int componentWidth(input int pixelDepth);
        return pixelDepth / NUM_COMPONENTS;
    endfunction

    function automatic int winIndex(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/gray_window_3x3_if.sv
// Pixel-in / window-out bundle of the gray_window_3x3 stage.
//   I_ENABLE, I_VALID, I_PIXEL    : upstream pixel stream (no backpressure)
//   O_VALID, O_WINDOW, O_FRAME_DONE : window stream towards the gradient stage
//   master : the side that drives pixels and observes windows
//   slave  : the window stage itself
interface gray_window_3x3_if #(
    parameter int P_PIXEL_DEPTH = 24
);
    localparam int S = gray_window_pkg::componentWidth(P_PIXEL_DEPTH);

    logic                                    I_ENABLE;
    logic                                    I_VALID;
    logic [P_PIXEL_DEPTH-1:0]                I_PIXEL;
    logic                                    O_VALID;
    logic [gray_window_pkg::WIN_ELEMS*S-1:0] O_WINDOW;
    logic                                    O_FRAME_DONE;

    modport master (
        output I_ENABLE, I_VALID, I_PIXEL,
        input  O_VALID, O_WINDOW, O_FRAME_DONE
    );

    modport slave (
        input  I_ENABLE, I_VALID, I_PIXEL,
        output O_VALID, O_WINDOW, O_FRAME_DONE
    );
endinterface

// File: rtl/gray_window_3x3_line_buffer.sv
// line_buffer: enable-gated shift register holding one image line.
//   I_CLK, I_RESET : clock, asynchronous active-high clear
//   shift_i        : advance the line by one entry
//   data_i         : entry shifted in at the head
//   tail_o         : oldest entry, i.e. the value shifted in P_DEPTH shifts ago
module line_buffer #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 64
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic               shift_i,
    input  logic [P_WIDTH-1:0] data_i,
    output logic [P_WIDTH-1:0] tail_o
);

    logic [P_WIDTH-1:0] stages_q [P_DEPTH];

    // Shift chain; the tail is read before the shift so it lags the head by exactly one line
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                stages_q[i] <= '0;
            end
        end else if (shift_i) begin
            stages_q[0] <= data_i;
            for (int i = 1; i < P_DEPTH; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign tail_o = stages_q[P_DEPTH-1];

endmodule

// File: rtl/gray_window_3x3.sv
// gray_window_3x3: sums three pre-weighted colour terms into a saturated gray
// sample, buffers two image lines and emits every interior 3x3 neighbourhood.
//   I_CLK, I_RESET : clock, asynchronous active-high reset
//   bus.I_ENABLE   : stage enable, all frame state holds while low
//   bus.I_VALID    : I_PIXEL carries a pixel this cycle
//   bus.I_PIXEL    : {red term, green term, blue term}, S bits each
//   bus.O_VALID    : one-cycle pulse, O_WINDOW holds a new window
//   bus.O_WINDOW   : element k = 3*r+c at [S*k +: S], r=0 oldest line, c=0 oldest column
//   bus.O_FRAME_DONE : one-cycle pulse after the last window of a frame
module gray_window_3x3
    import gray_window_pkg::*;
#(
    parameter int P_PIXEL_DEPTH  = 24,
    parameter int P_IMAGE_WIDTH  = 64,
    parameter int P_IMAGE_HEIGHT = 64
) (
    input logic              I_CLK,
    input logic              I_RESET,
    gray_window_3x3_if.slave bus
);

    localparam int S     = componentWidth(P_PIXEL_DEPTH);
    localparam int SUM_W = S + SUM_GUARD_BITS;
    localparam int COL_W = $clog2(P_IMAGE_WIDTH);
    localparam int ROW_W = $clog2(P_IMAGE_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_HEIGHT - 1);

    logic                   accept;
    logic [SUM_W-1:0]       graySum;
    logic [S-1:0]           gray;
    logic [S-1:0]           tapA;
    logic [S-1:0]           tapB;

    logic [S-1:0]           win_q [WIN_DIM][WIN_DIM];
    logic [S-1:0]           win_d [WIN_DIM][WIN_DIM];
    logic [WIN_ELEMS*S-1:0] window_q;
    logic [WIN_ELEMS*S-1:0] window_d;
    logic [COL_W-1:0]       colCount_q;
    logic [COL_W-1:0]       colCount_d;
    logic [ROW_W-1:0]       rowCount_q;
    logic [ROW_W-1:0]       rowCount_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   frameDone_q;
    logic                   frameDone_d;
    stateT                  state_q;
    stateT                  state_d;

    assign accept = bus.I_ENABLE & bus.I_VALID;

    // Gray sample: the two guard bits catch any carry out of S bits, which clamps to full scale
    always_comb begin
        graySum = SUM_W'(bus.I_PIXEL[3*S-1:2*S])
                + SUM_W'(bus.I_PIXEL[2*S-1:S])
                + SUM_W'(bus.I_PIXEL[S-1:0]);
        gray    = (graySum[SUM_W-1:S] != '0) ? '1 : graySum[S-1:0];
    end

    // Line A delays the gray stream by one line, line B by two
    line_buffer #(.P_WIDTH(S), .P_DEPTH(P_IMAGE_WIDTH)) lineA (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .shift_i (accept),
        .data_i  (gray),
        .tail_o  (tapA)
    );

    line_buffer #(.P_WIDTH(S), .P_DEPTH(P_IMAGE_WIDTH)) lineB (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .shift_i (accept),
        .data_i  (tapA),
        .tail_o  (tapB)
    );

    // Next window: columns slide towards c=0, the three line taps enter at c=2
    always_comb begin
        for (int r = 0; r < WIN_DIM; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = tapB;
        win_d[1][2] = tapA;
        win_d[2][2] = gray;
        window_d = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                window_d[winIndex(r, c)*S +: S] = win_d[r][c];
            end
        end
    end

    // Position of the accepted pixel; a window is complete only once two full
    // lines and two columns of the current line are in, which also keeps
    // windows from straddling a line wrap
    always_comb begin
        colCount_d = colCount_q;
        rowCount_d = rowCount_q;
        valid_d    = 1'b0;
        if (accept) begin
            valid_d = (rowCount_q >= ROW_W'(2)) && (colCount_q >= COL_W'(2));
            if (colCount_q == COL_LAST) begin
                colCount_d = '0;
                rowCount_d = (rowCount_q == ROW_LAST) ? '0 : rowCount_q + ROW_W'(1);
            end else begin
                colCount_d = colCount_q + COL_W'(1);
            end
        end
    end

    // Frame tracking; S_DONE lasts exactly one cycle so the done pulse cannot
    // stretch, and an accept there is already pixel (0,0) of the next frame
    always_comb begin
        state_d     = state_q;
        frameDone_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept && rowCount_q == ROW_W'(1) && colCount_q == COL_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && rowCount_q == ROW_LAST && colCount_q == COL_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frameDone_d = 1'b1;
                state_d     = accept ? S_FILL : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; the output window is only reloaded together with O_VALID
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q     <= S_IDLE;
            colCount_q  <= '0;
            rowCount_q  <= '0;
            valid_q     <= 1'b0;
            frameDone_q <= 1'b0;
            window_q    <= '0;
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            colCount_q  <= colCount_d;
            rowCount_q  <= rowCount_d;
            valid_q     <= valid_d;
            frameDone_q <= frameDone_d;
            if (accept) begin
                win_q <= win_d;
            end
            if (valid_d) begin
                window_q <= window_d;
            end
        end
    end

    assign bus.O_VALID      = valid_q;
    assign bus.O_WINDOW     = window_q;
    assign bus.O_FRAME_DONE = frameDone_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Testbench for gray_window_3x3: a 4x4 instance (dut0) and a 3x3 instance
// (dut1) share clock and reset. An image-level model predicts every output
// on every cycle; directed literals pin the model's key results.
module tb_gray_window_3x3;

    localparam int DEPTH = 24;
    localparam int WBITS = 72;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gray_window_3x3_if #(.P_PIXEL_DEPTH(DEPTH)) bus0 ();
    gray_window_3x3_if #(.P_PIXEL_DEPTH(DEPTH)) bus1 ();

    gray_window_3x3 #(.P_PIXEL_DEPTH(DEPTH), .P_IMAGE_WIDTH(4), .P_IMAGE_HEIGHT(4)) dut0 (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus0)
    );

    gray_window_3x3 #(.P_PIXEL_DEPTH(DEPTH), .P_IMAGE_WIDTH(3), .P_IMAGE_HEIGHT(3)) dut1 (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus1)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Image model state, index 0 = 4x4 instance, 1 = 3x3 instance
    int               widthOf  [2] = '{4, 3};
    int               heightOf [2] = '{4, 3};
    int               pos      [2];
    logic [7:0]       img      [2][4][4];
    logic             expValid [2];
    logic [WBITS-1:0] expWin   [2];
    logic             expDone  [2];
    logic             doneArm  [2];

    // Observation logs
    int               cycle = 0;
    int               accIdx0;
    int               validAt0[$];
    logic [WBITS-1:0] winLog0[$];
    int               doneCnt0, doneCyc0, lastValidCyc0;
    logic [WBITS-1:0] winLog1[$];
    int               doneCnt1, doneCyc1, lastValidCyc1;

    // Expected 4x4 windows for pixels g=n, centres 5, 6, 9, 10
    logic [WBITS-1:0] frameWin [4] = '{
        72'h0A0908_060504_020100,
        72'h0B0A09_070605_030201,
        72'h0E0D0C_0A0908_060504,
        72'h0F0E0D_0B0A09_070605
    };
    int frameAt [4] = '{10, 11, 14, 15};

    function automatic logic [7:0] grayOf(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
        return (s > 255) ? 8'hFF : s[7:0];
    endfunction

    // Advance the image model by one clock edge
    task automatic modelStep(input int id, input logic inReset, input logic acc, input logic [23:0] pix);
        int row;
        int col;
        if (inReset) begin
            pos[id]      = 0;
            expValid[id] = 1'b0;
            expWin[id]   = '0;
            expDone[id]  = 1'b0;
            doneArm[id]  = 1'b0;
        end else begin
            expDone[id]  = doneArm[id];
            doneArm[id]  = 1'b0;
            expValid[id] = 1'b0;
            if (acc) begin
                row = pos[id] / widthOf[id];
                col = pos[id] % widthOf[id];
                img[id][row][col] = grayOf(pix);
                if (row >= 2 && col >= 2) begin
                    expValid[id] = 1'b1;
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            expWin[id][8*(3*r+c) +: 8] = img[id][row-2+r][col-2+c];
                        end
                    end
                end
                if (pos[id] == widthOf[id]*heightOf[id] - 1) begin
                    doneArm[id] = 1'b1;
                end
                pos[id] = (pos[id] + 1) % (widthOf[id]*heightOf[id]);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [WBITS-1:0] act, input logic [WBITS-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic en, input logic valid, input logic [23:0] pix);
        @(negedge clk);
        bus0.I_ENABLE = (id == 0) ? en    : 1'b0;
        bus0.I_VALID  = (id == 0) ? valid : 1'b0;
        bus0.I_PIXEL  = (id == 0) ? pix   : 24'h0;
        bus1.I_ENABLE = (id == 1) ? en    : 1'b0;
        bus1.I_VALID  = (id == 1) ? valid : 1'b0;
        bus1.I_PIXEL  = (id == 1) ? pix   : 24'h0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic clearLogs();
        accIdx0 = 0;
        validAt0.delete();
        winLog0.delete();
        doneCnt0 = 0; doneCyc0 = -100; lastValidCyc0 = 0;
        winLog1.delete();
        doneCnt1 = 0; doneCyc1 = -100; lastValidCyc1 = 0;
    endtask

    function automatic logic [WBITS-1:0] win0At(input int i);
        return (i < winLog0.size()) ? winLog0[i] : 'x;
    endfunction

    function automatic int at0(input int i);
        return (i < validAt0.size()) ? validAt0[i] : 999;
    endfunction

    task automatic checkFrameWindows(input string tag);
        checkOutput({tag, "Count"}, WBITS'(winLog0.size()), WBITS'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%sWin%0d", tag, i), win0At(i), frameWin[i]);
            checkOutput($sformatf("%sAt%0d", tag, i), WBITS'(at0(i)), WBITS'(frameAt[i]));
        end
        checkOutput({tag, "DoneCount"}, WBITS'(doneCnt0), WBITS'(1));
        checkOutput({tag, "DoneAfterLast"}, WBITS'(doneCyc0 - lastValidCyc0), WBITS'(1));
    endtask

    // Single compare process: advance the model at each edge, check the DUTs just after
    initial begin : compareProc
        logic             r;
        logic             a0, a1;
        logic [23:0]      p0, p1;
        forever begin
            @(posedge clk);
            r  = rst;
            a0 = bus0.I_ENABLE & bus0.I_VALID;
            a1 = bus1.I_ENABLE & bus1.I_VALID;
            p0 = bus0.I_PIXEL;
            p1 = bus1.I_PIXEL;
            modelStep(0, r, a0, p0);
            modelStep(1, r, a1, p1);
            cycle++;
            if (a0 && !r) accIdx0++;
            #1;
            checkOutput("valid0", WBITS'(bus0.O_VALID), WBITS'(expValid[0]));
            checkOutput("window0", bus0.O_WINDOW, expWin[0]);
            checkOutput("done0", WBITS'(bus0.O_FRAME_DONE), WBITS'(expDone[0]));
            checkOutput("valid1", WBITS'(bus1.O_VALID), WBITS'(expValid[1]));
            checkOutput("window1", bus1.O_WINDOW, expWin[1]);
            checkOutput("done1", WBITS'(bus1.O_FRAME_DONE), WBITS'(expDone[1]));
            if (bus0.O_VALID === 1'b1) begin
                validAt0.push_back(accIdx0 - 1);
                winLog0.push_back(bus0.O_WINDOW);
                lastValidCyc0 = cycle;
            end
            if (bus0.O_FRAME_DONE === 1'b1) begin
                doneCnt0++;
                doneCyc0 = cycle;
            end
            if (bus1.O_VALID === 1'b1) begin
                winLog1.push_back(bus1.O_WINDOW);
                lastValidCyc1 = cycle;
            end
            if (bus1.O_FRAME_DONE === 1'b1) begin
                doneCnt1++;
                doneCyc1 = cycle;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : mainSeq
        logic [WBITS-1:0] w;
        logic [23:0]      pix;

        rst = 1'b1;
        bus0.I_ENABLE = 1'b0; bus0.I_VALID = 1'b0; bus0.I_PIXEL = '0;
        bus1.I_ENABLE = 1'b0; bus1.I_VALID = 1'b0; bus1.I_PIXEL = '0;
        clearLogs();
        repeat (2) @(negedge clk);
        checkOutput("resetValid", WBITS'(bus0.O_VALID), WBITS'(0));
        checkOutput("resetWindow", bus0.O_WINDOW, WBITS'(0));
        checkOutput("resetDone", WBITS'(bus0.O_FRAME_DONE), WBITS'(0));
        rst = 1'b0;

        // Plain 4x4 frame, blue term = n
        $display("[TB] frame of 16 ramp pixels");
        clearLogs();
        for (int n = 0; n < 16; n++) applyStimulus(0, 1'b1, 1'b1, 24'(n));
        idleCycles(3);
        checkFrameWindows("ramp");

        // Saturation of the three-term sum
        $display("[TB] saturation");
        clearLogs();
        for (int n = 0; n < 16; n++) begin
            pix = (n == 0) ? 24'hFFFFFF : (n == 1) ? 24'h102030 : (n == 2) ? 24'h808080 : 24'(n);
            applyStimulus(0, 1'b1, 1'b1, pix);
        end
        idleCycles(3);
        w = win0At(0);
        checkOutput("satFull", WBITS'(w[7:0]), WBITS'(8'hFF));
        checkOutput("satNone", WBITS'(w[15:8]), WBITS'(8'h60));
        checkOutput("satCarry", WBITS'(w[23:16]), WBITS'(8'hFF));
        checkOutput("satCentre", WBITS'(w[39:32]), WBITS'(8'h05));

        // Same frame with bubbles and a 5-cycle enable hold mid-row
        $display("[TB] gaps and enable hold");
        clearLogs();
        for (int n = 0; n < 16; n++) begin
            applyStimulus(0, 1'b1, 1'b1, 24'(n));
            if (n == 5) begin
                repeat (5) applyStimulus(0, 1'b0, 1'b1, 24'hFFFFFF);
            end else begin
                applyStimulus(0, 1'b1, 1'b0, 24'hABCDEF);
            end
        end
        idleCycles(3);
        checkFrameWindows("gaps");

        // Reset after 9 pixels clears outputs immediately
        $display("[TB] reset mid-frame");
        for (int n = 0; n < 9; n++) applyStimulus(0, 1'b1, 1'b1, 24'(n + 100));
        @(negedge clk);
        bus0.I_ENABLE = 1'b0; bus0.I_VALID = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetValid", WBITS'(bus0.O_VALID), WBITS'(0));
        checkOutput("midResetWindow", bus0.O_WINDOW, WBITS'(0));
        checkOutput("midResetDone", WBITS'(bus0.O_FRAME_DONE), WBITS'(0));
        @(negedge clk);
        rst = 1'b0;
        clearLogs();
        for (int n = 0; n < 16; n++) applyStimulus(0, 1'b1, 1'b1, 24'(n));
        idleCycles(3);
        checkFrameWindows("afterReset");

        // Two frames back to back, second frame g = n + 16
        $display("[TB] back-to-back frames");
        clearLogs();
        for (int n = 0; n < 32; n++) applyStimulus(0, 1'b1, 1'b1, 24'(n));
        idleCycles(3);
        checkOutput("b2bCount", WBITS'(winLog0.size()), WBITS'(8));
        checkOutput("b2bDoneCount", WBITS'(doneCnt0), WBITS'(2));
        w = win0At(4);
        checkOutput("b2bFirstWin2", w, 72'h1A1918_161514_121110);
        checkOutput("b2bCentre", WBITS'(w[39:32]), WBITS'(21));
        checkOutput("b2bLastWin2", win0At(7), 72'h1F1E1D_1B1A19_171615);

        // Minimum 3x3 image on the second instance
        $display("[TB] 3x3 image");
        clearLogs();
        for (int n = 0; n < 9; n++) applyStimulus(1, 1'b1, 1'b1, 24'(n));
        idleCycles(3);
        checkOutput("w3Count", WBITS'(winLog1.size()), WBITS'(1));
        checkOutput("w3Win", (winLog1.size() > 0) ? winLog1[0] : 'x, 72'h080706_050403_020100);
        checkOutput("w3DoneCount", WBITS'(doneCnt1), WBITS'(1));
        checkOutput("w3DoneAfterLast", WBITS'(doneCyc1 - lastValidCyc1), WBITS'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
